// File: rtl/jb_dfe_pkg.sv
// Shared types and default sizes for the DFE antenna TDM path.
package jb_dfe_pkg;

    localparam int DEF_N_ANTENNAS = 4;
    localparam int DEF_PRECISION  = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_USR_ID_BW  = 2;

    typedef enum logic {
        TDM_IDLE = 1'b0,
        TDM_SEND = 1'b1
    } tdm_state_e;

    typedef logic [DEF_USR_ID_BW-1:0]   ant_idx_t;
    typedef logic [2*DEF_PRECISION-1:0] sample_t;

endpackage

// File: rtl/jb_axi4_stream_if.sv
// Minimal AXI4-stream bundle used on the shared DFE bus.
interface jb_axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 2
) ();
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/jb_dfe_lane_fifo.sv
// Per-lane synchronous skid FIFO; pointers carry one extra wrap bit for full/empty.
module jb_dfe_lane_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk_4x,
    input  logic                     rst_4x,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_4x) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_4x) begin
        if (rst_4x) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/jb_dfe_ant_tdm_mux.sv
// Antenna TDM packer: per-antenna lanes in, one antenna-interleaved AXI4-stream out.
module jb_dfe_ant_tdm_mux
    import jb_dfe_pkg::*;
#(
    parameter int N_ANTENNAS = DEF_N_ANTENNAS,
    parameter int PRECISION  = DEF_PRECISION,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int USR_ID_BW  = DEF_USR_ID_BW
) (
    input  logic                                     clk_4x,
    input  logic                                     rst_4x,
    input  logic                                     enable,
    input  logic                                     err_clr,
    input  logic [N_ANTENNAS-1:0]                    s_tvalid,
    input  logic [N_ANTENNAS-1:0][2*PRECISION-1:0]   s_tdata,
    output logic [N_ANTENNAS-1:0]                    s_tready,
    jb_axi4_stream_if.master                         IFP_dfe_tdm_out,
    output logic                                     err_skew,
    output tdm_state_e                               dbg_state
);

    localparam int DW = 2 * PRECISION;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [USR_ID_BW-1:0] K_LAST = USR_ID_BW'(N_ANTENNAS - 1);

    logic [N_ANTENNAS-1:0] lane_push;
    logic [N_ANTENNAS-1:0] lane_pop;
    logic [N_ANTENNAS-1:0] lane_full;
    logic [N_ANTENNAS-1:0] lane_empty;
    logic [DW-1:0]         lane_dout [N_ANTENNAS];
    logic [CW-1:0]         lane_cnt  [N_ANTENNAS];

    tdm_state_e            state;
    logic [USR_ID_BW-1:0]  k;
    logic                  out_tvalid;
    logic                  out_tlast;
    logic [DW-1:0]         out_tdata;
    logic [USR_ID_BW-1:0]  out_tuser;

    logic all_ne;
    logic load;
    logic last_lane_refill;
    logic any_full;
    logic any_empty;

    // Both sides use valid/ready: a beat transfers on a cycle where valid and ready are
    // both high; once valid is raised the payload is held until that transfer happens.
    assign s_tready  = ~lane_full & {N_ANTENNAS{~rst_4x}};
    assign lane_push = s_tvalid & s_tready;

    for (genvar a = 0; a < N_ANTENNAS; a++) begin : g_lane
        jb_dfe_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DW)
        ) u_fifo (
            .clk_4x (clk_4x),
            .rst_4x (rst_4x),
            .push   (lane_push[a]),
            .pop    (lane_pop[a]),
            .din    (s_tdata[a]),
            .dout   (lane_dout[a]),
            .count  (lane_cnt[a]),
            .full   (lane_full[a]),
            .empty  (lane_empty[a])
        );
    end

    assign all_ne   = ~|lane_empty;
    assign load     = (state == TDM_SEND) && (!out_tvalid || IFP_dfe_tdm_out.tready);
    assign lane_pop = load ? (N_ANTENNAS'(1) << k) : '0;
    // The last lane is popped in the same cycle the next-frame decision is made,
    // so it needs a second sample queued for the following frame to start gap-free.
    assign last_lane_refill = (lane_cnt[N_ANTENNAS-1] >= CW'(2));

    always_comb begin
        any_full  = 1'b0;
        any_empty = 1'b0;
        for (int a = 0; a < N_ANTENNAS; a++) begin
            if (lane_cnt[a] == CW'(FIFO_DEPTH)) any_full = 1'b1;
            if (lane_cnt[a] == '0)              any_empty = 1'b1;
        end
    end

    always_ff @(posedge clk_4x) begin
        if (rst_4x) begin
            state      <= TDM_IDLE;
            k          <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= '0;
        end else begin
            if (load) begin
                out_tvalid <= 1'b1;
                out_tdata  <= lane_dout[k];
                out_tuser  <= k;
                out_tlast  <= (k == K_LAST);
            end else if (IFP_dfe_tdm_out.tready) begin
                out_tvalid <= 1'b0;
                out_tlast  <= 1'b0;
            end

            case (state)
                TDM_IDLE: begin
                    if (enable && all_ne) begin
                        state <= TDM_SEND;
                        k     <= '0;
                    end
                end
                TDM_SEND: begin
                    if (load) begin
                        if (k == K_LAST) begin
                            k <= '0;
                            if (!(enable && all_ne && last_lane_refill)) state <= TDM_IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= TDM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_4x) begin
        if (rst_4x) begin
            err_skew <= 1'b0;
        end else if (any_full && any_empty) begin
            err_skew <= 1'b1;
        end else if (err_clr) begin
            err_skew <= 1'b0;
        end
    end

    assign IFP_dfe_tdm_out.tvalid = out_tvalid;
    assign IFP_dfe_tdm_out.tdata  = out_tdata;
    assign IFP_dfe_tdm_out.tuser  = out_tuser;
    assign IFP_dfe_tdm_out.tlast  = out_tlast;
    assign dbg_state              = state;

endmodule

// File: tb/tb_jb_dfe_ant_tdm_mux.sv
// Bench for the antenna TDM packer: directed timing cases plus randomized traffic vs a frame model.
module tb_jb_dfe_ant_tdm_mux;
    import jb_dfe_pkg::*;

    localparam int NA = 4;
    localparam int DW = 32;

    logic                   clk_4x = 1'b0;
    logic                   rst_4x;
    logic                   enable;
    logic                   err_clr;
    logic [NA-1:0]          s_tvalid;
    logic [NA-1:0][DW-1:0]  s_tdata;
    logic [NA-1:0]          s_tready;
    logic                   err_skew;
    tdm_state_e             dbg_state;
    logic                   out_tready;

    jb_axi4_stream_if #(.DATA_W(DW), .USER_W(2)) out_if ();
    assign out_if.tready = out_tready;

    jb_dfe_ant_tdm_mux dut (
        .clk_4x          (clk_4x),
        .rst_4x          (rst_4x),
        .enable          (enable),
        .err_clr         (err_clr),
        .s_tvalid        (s_tvalid),
        .s_tdata         (s_tdata),
        .s_tready        (s_tready),
        .IFP_dfe_tdm_out (out_if),
        .err_skew        (err_skew),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_4x = ~clk_4x;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_err    = 0;
    logic [34:0] exp_q [$];
    sample_t     lane_q [NA][$];
    int          beat_cnt = 0;
    logic        last_tlast = 1'b0;
    logic [1:0]  last_tuser = 2'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a frame exists once every lane holds a sample; it goes out as ant0..antN-1.
    task automatic model_frames();
        logic [34:0] b;
        while (lane_q[0].size() > 0 && lane_q[1].size() > 0 &&
               lane_q[2].size() > 0 && lane_q[3].size() > 0) begin
            for (int a = 0; a < NA; a++) begin
                b = {(a == NA - 1), 2'(a), lane_q[a].pop_front()};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int a = 0; a < NA; a++) lane_q[a].delete();
    endtask

    always @(negedge clk_4x) begin
        if (!rst_4x) begin
            if (out_if.tvalid && out_tready) begin
                beat_cnt++;
                last_tlast = out_if.tlast;
                last_tuser = out_if.tuser;
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("beat", {out_if.tlast, out_if.tuser, out_if.tdata}, exp_q.pop_front());
            end
            for (int a = 0; a < NA; a++)
                if (s_tvalid[a] && s_tready[a]) lane_q[a].push_back(s_tdata[a]);
            model_frames();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_4x);
        #1;
    endtask

    task automatic do_reset();
        rst_4x   = 1'b1;
        s_tvalid = '0;
        err_clr  = 1'b0;
        repeat (5) tick();
        model_clear();
        rst_4x = 1'b0;
        tick();
    endtask

    task automatic push_lanes(input logic [NA-1:0] mask, input logic [DW-1:0] base);
        for (int a = 0; a < NA; a++) s_tdata[a] = base + DW'(a);
        s_tvalid = mask;
        @(posedge clk_4x);
        #1;
        s_tvalid = '0;
    endtask

    task automatic measure_latency(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_if.tvalid && lat < 50) begin
            tick();
            lat++;
        end
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || out_if.tvalid) && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic drive_stream();
        s_tvalid = '1;
        for (int a = 0; a < NA; a++) s_tdata[a] = $urandom;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b0;
        int n;

        rst_4x = 1'b1; enable = 1'b0; err_clr = 1'b0;
        s_tvalid = '0; s_tdata = '0; out_tready = 1'b1;

        // Reset / idle
        repeat (5) tick();
        check("rst_s_tready", 64'(s_tready), 64'h0);
        check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("rst_tlast", 64'(out_if.tlast), 64'd0);
        check("rst_tdata", 64'(out_if.tdata), 64'd0);
        check("rst_tuser", 64'(out_if.tuser), 64'd0);
        check("rst_err_skew", 64'(err_skew), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(TDM_IDLE));
        rst_4x = 1'b0;
        tick();
        check("post_rst_s_tready", 64'(s_tready), 64'hF);
        check("post_rst_tvalid", 64'(out_if.tvalid), 64'd0);

        // Aligned frame
        enable = 1'b1;
        push_lanes(4'hF, 32'h0000_0010);
        measure_latency("aligned_latency", 2);
        check("aligned_first_tuser", 64'(out_if.tuser), 64'd0);
        check("aligned_first_tdata", 64'(out_if.tdata), 64'h10);
        drain("aligned_drain", 20);

        // Skewed arrival: lane 2 six cycles late
        push_lanes(4'b1011, 32'h0000_0020);
        b0 = beat_cnt;
        repeat (5) tick();
        check("skew_no_beat", 64'(beat_cnt - b0), 64'd0);
        check("skew_tvalid_low", 64'(out_if.tvalid), 64'd0);
        push_lanes(4'b0100, 32'h0000_0020);
        measure_latency("skew_latency", 2);
        drain("skew_drain", 20);

        // Backpressure on the tuser=1 beat
        push_lanes(4'hF, 32'h0000_0030);
        repeat (3) tick();
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_tvalid", 64'(out_if.tvalid), 64'd1);
            check("bp_tuser", 64'(out_if.tuser), 64'd1);
            check("bp_tdata", 64'(out_if.tdata), 64'h31);
            check("bp_tlast", 64'(out_if.tlast), 64'd0);
            tick();
        end
        out_tready = 1'b1;
        drain("bp_drain", 20);

        // Reset mid-frame drops the frame
        push_lanes(4'hF, 32'h0000_0060);
        repeat (3) tick();
        rst_4x = 1'b1;
        tick();
        check("midrst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("midrst_tlast", 64'(out_if.tlast), 64'd0);
        do_reset();

        // Full / skew flag
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("full_ready_before", 64'(s_tready[0]), 64'd1);
            push_lanes(4'b0001, 32'h40 + 32'(i) - 32'(0));
        end
        check("full_ready_after", 64'(s_tready), 64'hE);
        tick();
        check("skew_set", 64'(err_skew), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("skew_set_wins", 64'(err_skew), 64'd1);
        push_lanes(4'b1110, 32'h0000_0050);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("skew_cleared", 64'(err_skew), 64'd0);
        drain("full_drain", 30);
        do_reset();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 800; c++) begin
            for (int a = 0; a < NA; a++) begin
                s_tvalid[a] = ($urandom_range(0, 9) < 4 + a);
                s_tdata[a]  = $urandom;
            end
            out_tready = ($urandom_range(0, 9) < 7);
            tick();
        end
        s_tvalid   = '0;
        out_tready = 1'b1;
        drain("rand_drain", 300);
        do_reset();

        // Streaming, throughput, then enable drop mid-frame
        for (int c = 0; c < 10; c++) begin drive_stream(); tick(); end
        b0 = beat_cnt;
        for (int c = 0; c < 40; c++) begin drive_stream(); tick(); end
        check("throughput_beats", 64'(beat_cnt - b0), 64'd40);
        n = 0;
        while (!(out_if.tvalid && out_if.tuser == 2'd1) && n < 20) begin
            drive_stream();
            tick();
            n++;
        end
        check("found_tuser1", 64'(out_if.tuser), 64'd1);
        enable = 1'b0;
        b0 = beat_cnt;
        for (int c = 0; c < 20; c++) begin drive_stream(); tick(); end
        check("drop_beats", 64'(beat_cnt - b0), 64'd3);
        check("drop_last_tuser", 64'(last_tuser), 64'd3);
        check("drop_last_tlast", 64'(last_tlast), 64'd1);
        check("drop_state_idle", 64'(dbg_state), 64'(TDM_IDLE));
        check("drop_lanes_full", 64'(s_tready), 64'h0);
        s_tvalid = '0;
        enable   = 1'b1;
        drain("resume_drain", 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
